spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
SPI mode-0 master that runs single-register transactions against the robot's FPGA SPI register file. It is the initiator end of that interface, the same role the Raspberry Pi plays. It is used in two ways: as a self-test initiator driven from internal logic, and as the reference master in benches for the register-file slave. Each transaction is one 40-bit frame: an 8-bit command byte followed by a 32-bit data word, MSB first.

Parameters:
CLK_DIV, 25, clk cycles per SCLK half-period (50 MHz -> 1 MHz SCLK); legal values 1..255
CS_SETUP, 4, clk cycles from CS low to first SCLK rising edge
CS_HOLD, 4, clk cycles from last SCLK falling edge to CS high
GAP, 8, minimum clk cycles CS stays high between frames

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; accepted only when busy=0
rw  in  1  1 = write, 0 = read; latched on accept
addr  in  7  register word address (byte address >> 2); latched on accept
wdata  in  32  write data; latched on accept
busy  out  1  high from the cycle after an accepted start through the end of GAP
done  out  1  one-cycle pulse at frame completion
rdata  out  32  last 32 MISO bits of the completed frame; stable until the next done
spi_clk  out  1  SCLK; idles low
spi_cs  out  1  chip select, active low
spi_mosi  out  1  master out
spi_miso  in  1  slave in; MISO is tri-stated by the slave when CS is high

Behaviour:
- Reset (synchronous, active-high) forces all of the following on the next edge, including mid-frame, with no partial done:
  - spi_cs=1, spi_clk=0, spi_mosi=0
  - busy=0, done=0, rdata=0
  - state=IDLE, all counters 0
- Frame layout: tx[39:0] = {rw, addr[6:0], wdata[31:0]}. For a read, the data field is sent as 0.
- States and transitions:
  - IDLE: start=1 latches the frame into tx_sr, sets spi_mosi=tx[39], and enters SETUP. spi_cs goes low in the same cycle as busy goes high.
  - SETUP: counts CS_SETUP cycles, then enters SHIFT.
  - SHIFT: uses a half-period tick every CLK_DIV cycles and a bit counter 0..39.
    - Rising tick: spi_clk goes 1 and spi_miso is sampled into rx_sr (shift left, LSB in).
    - Falling tick: spi_clk goes 0. If the bit counter is below 39, tx_sr shifts and spi_mosi presents the next bit.
    - After the falling tick of bit 39, enter HOLD. spi_mosi is then held at the last bit.
  - HOLD: counts CS_HOLD cycles, then sets spi_cs=1, rdata=rx_sr[31:0], and done=1 for that single cycle. Enters GAP.
  - GAP: counts GAP cycles, then returns to IDLE with busy=0.
- Latency: start to done = 1 + CS_SETUP + 80*CLK_DIV + CS_HOLD cycles. With default parameters that is 2009 cycles.
- A start while busy=1 is ignored. There is no queueing and no error flag.
- A start held high continuously issues back-to-back frames, separated by exactly GAP cycles of CS high.
- The 8 MISO bits sampled during the command byte are discarded.
- rdata is updated on writes as well, capturing the slave's read-back.
- MISO is used directly with no synchronizer, because sampling occurs at the clk edge that generates SCLK. Slave MISO must be stable at least 1 clk cycle before the SCLK rising edge.
- CLK_DIV=1 is legal: every cycle in SHIFT toggles SCLK (25 MHz SCLK at 50 MHz clk).

Decomposition:
- Package spi_pkg holds:
  - state enum {IDLE, SETUP, SHIFT, HOLD, GAP}
  - FRAME_BITS=40, CMD_BITS=8, DATA_BITS=32
  - RW_BIT=39
  - register word-address constants: 1=mot_left, 2=mot_right, 3=laser_a, 4=laser_b, 5=posBeacon, 6=negBeacon, 7=nTikz
- One sub-module, spi_tick_gen, generates the half-period tick. Its interface is clk, reset, en, tick, with parameter CLK_DIV. Its counter clears while en=0.

Test Plan:
- Read of addr=7'h07 with CLK_DIV=2 against a slave model returning 32'hDEADBEEF -> MOSI first byte 8'h07, data bits all 0; done exactly 1+4+160+4=169 cycles after start; rdata=32'hDEADBEEF.
- Write rw=1, addr=7'h01, wdata=32'h12345678 -> MOSI stream 40'h81_12345678 MSB first; exactly 40 SCLK rising edges while CS low; SCLK low whenever CS is high.
- start re-pulsed at cycle 10 and cycle 100 of an active frame -> ignored; exactly one done; no extra SCLK edges.
- start held high for 3 frames -> 3 done pulses; CS high for exactly 8 cycles between frames; rdata updates only at each done.
- reset asserted at bit 20 of a frame -> next cycle spi_cs=1, spi_clk=0, busy=0, rdata=0, no done pulse; a following start produces a full, correct 40-bit frame.
- CLK_DIV=1, read with slave returning 32'h0000_0005 -> SCLK toggles every cycle; rdata=32'h00000005; done 1+4+80+4=89 cycles after start.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 register-file master: state
// encoding, frame geometry, register word addresses and frame packing.
package spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    localparam int FRAME_BITS = 40;
    localparam int CMD_BITS   = 8;
    localparam int DATA_BITS  = 32;
    localparam int RW_BIT     = 39;

    // Register word addresses (byte address >> 2) in the FPGA register file
    localparam logic [6:0] ADDR_MOT_LEFT   = 7'd1;
    localparam logic [6:0] ADDR_MOT_RIGHT  = 7'd2;
    localparam logic [6:0] ADDR_LASER_A    = 7'd3;
    localparam logic [6:0] ADDR_LASER_B    = 7'd4;
    localparam logic [6:0] ADDR_POS_BEACON = 7'd5;
    localparam logic [6:0] ADDR_NEG_BEACON = 7'd6;
    localparam logic [6:0] ADDR_NTIKZ      = 7'd7;

    // Command byte is {rw, addr}; reads carry an all-zero data field
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic                 rw,
        input logic [6:0]           addr,
        input logic [DATA_BITS-1:0] wdata
    );
        logic [DATA_BITS-1:0] data_s;
        data_s = rw ? wdata : {DATA_BITS{1'b0}};
        return {rw, addr, data_s};
    endfunction

endpackage

// File: rtl/spi_master_tick_gen.sv
// Half-period tick generator for SCLK. The counter is held at zero while
// disabled so every shift phase starts with a full half-period.
module spi_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Next count: wrap at the last cycle of each half-period, clear when idle
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = 8'd0;
        end else if (cnt_q == DIV_LAST) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == DIV_LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master issuing one 40-bit frame ({rw, addr, data}, MSB first)
// per accepted start. All SPI pins and handshake outputs come from flops.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 25,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int GAP      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rw,
    input  logic [6:0]  addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        spi_clk,
    output logic        spi_cs,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);
    // The done cycle is already the first CS-high cycle and the IDLE cycle
    // the last, so GAP state itself lasts GAP-1 cycles.
    localparam logic [15:0] GAP_LAST   = 16'((GAP >= 2) ? (GAP - 2) : 0);
    localparam logic [5:0]  LAST_BIT   = 6'(FRAME_BITS - 1);

    state_e         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [5:0]     bit_cnt_q, bit_cnt_d;
    logic [39:0]    tx_sr_q, tx_sr_d;
    logic [31:0]    rx_sr_q, rx_sr_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           sclk_q, sclk_d;
    logic           cs_q, cs_d;
    logic           mosi_q, mosi_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           shift_en_s;
    logic           tick_s;
    logic [39:0]    frame_s;

    assign shift_en_s = (state_q == S_SHIFT);
    assign frame_s    = build_frame(rw, addr, wdata);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (shift_en_s),
        .tick  (tick_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SETUP;
                else       state_d = S_IDLE;
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = S_SHIFT;
                else                     state_d = S_SETUP;
            end
            S_SHIFT: begin
                if (tick_s && sclk_q && (bit_cnt_q == LAST_BIT)) state_d = S_HOLD;
                else                                             state_d = S_SHIFT;
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = S_GAP;
                else                    state_d = S_HOLD;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) state_d = S_IDLE;
                else                   state_d = S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output values for each state
    always_comb begin
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rdata_d   = rdata_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d     = 16'd0;
                bit_cnt_d = 6'd0;
                if (start) begin
                    tx_sr_d = frame_s;
                    mosi_d  = frame_s[RW_BIT];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) cnt_d = 16'd0;
                else                     cnt_d = cnt_q + 16'd1;
            end
            S_SHIFT: begin
                if (tick_s) begin
                    if (!sclk_q) begin
                        // Rising edge: slave data has been stable a full clk
                        sclk_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[30:0], spi_miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q != LAST_BIT) begin
                            tx_sr_d   = {tx_sr_q[38:0], 1'b0};
                            mosi_d    = tx_sr_q[38];
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end else begin
                            bit_cnt_d = 6'd0;
                        end
                    end
                end else begin
                    sclk_d = sclk_q;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 16'd0;
                    cs_d    = 1'b1;
                    rdata_d = rx_sr_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d  = 16'd0;
                    busy_d = 1'b0;
                end else begin
                    cnt_d  = cnt_q + 16'd1;
                end
            end
            default: begin
                cnt_d  = 16'd0;
                cs_d   = 1'b1;
                sclk_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset abandons any frame without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 16'd0;
            bit_cnt_q <= 6'd0;
            tx_sr_q   <= 40'd0;
            rx_sr_q   <= 32'd0;
            rdata_q   <= 32'd0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rdata_q   <= rdata_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rdata    = rdata_q;
    assign spi_clk  = sclk_q;
    assign spi_cs   = cs_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=2 and CLK_DIV=1) with a
// behavioural mode-0 slave that records MOSI, serves MISO and logs timing.
module tb_spi_master;

    localparam int DIV0 = 2;
    localparam int DIV1 = 1;
    localparam int LAT0 = 1 + 4 + 80 * DIV0 + 4;
    localparam int LAT1 = 1 + 4 + 80 * DIV1 + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  reset_v = 2'b11;
    logic [1:0]  start_v = 2'b00;
    logic [1:0]  rw_v    = 2'b00;
    logic [1:0]  busy_v, done_v, sclk_v, cs_v, mosi_v;
    logic [6:0]  addr_a  [2];
    logic [31:0] wdata_a [2];
    logic [31:0] rdata_a [2];
    logic        miso_a  [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Slave/monitor state, written only by the monitor process
    int          rises     [2] = '{0, 0};
    int          dones     [2] = '{0, 0};
    int          falls     [2] = '{0, 0};
    int          sclk_bad  [2] = '{0, 0};
    int          rdata_bad [2] = '{0, 0};
    int          bit_idx   [2] = '{0, 0};
    int          hi_run    [2] = '{0, 0};
    int          cur_frame [2] = '{0, 0};
    logic        prev_cs   [2] = '{1'b1, 1'b1};
    logic        prev_sclk [2] = '{1'b0, 1'b0};
    logic [31:0] prev_rd   [2] = '{32'd0, 32'd0};
    logic [39:0] mosi_cap  [2];
    int          done_cyc  [2][32];
    logic [31:0] done_rd   [2][32];
    int          gap_log   [2][32];
    // Slave response per frame index, written only by the stimulus block
    logic [31:0] resp_tab  [2][32];

    spi_master #(.CLK_DIV(DIV0), .CS_SETUP(4), .CS_HOLD(4), .GAP(8)) dut0 (
        .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .rw(rw_v[0]),
        .addr(addr_a[0]), .wdata(wdata_a[0]), .busy(busy_v[0]), .done(done_v[0]),
        .rdata(rdata_a[0]), .spi_clk(sclk_v[0]), .spi_cs(cs_v[0]),
        .spi_mosi(mosi_v[0]), .spi_miso(miso_a[0]));

    spi_master #(.CLK_DIV(DIV1), .CS_SETUP(4), .CS_HOLD(4), .GAP(8)) dut1 (
        .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .rw(rw_v[1]),
        .addr(addr_a[1]), .wdata(wdata_a[1]), .busy(busy_v[1]), .done(done_v[1]),
        .rdata(rdata_a[1]), .spi_clk(sclk_v[1]), .spi_cs(cs_v[1]),
        .spi_mosi(mosi_v[1]), .spi_miso(miso_a[1]));

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slave: shifts MISO on SCLK falls, captures MOSI on rises
    always @(negedge clk) begin : mon
        logic [31:0] rv;
        for (int g = 0; g < 2; g++) begin
            if (cs_v[g] === 1'b1 && sclk_v[g] === 1'b1) sclk_bad[g]++;
            if (done_v[g] === 1'b1) begin
                done_cyc[g][dones[g] % 32] = cyc;
                done_rd[g][dones[g] % 32]  = rdata_a[g];
                dones[g]++;
            end else if (!reset_v[g] && rdata_a[g] !== prev_rd[g]) begin
                rdata_bad[g]++;
            end
            prev_rd[g] = rdata_a[g];
            if (cs_v[g] !== 1'b0) begin
                hi_run[g]++;
                bit_idx[g] = 0;
            end else begin
                if (prev_cs[g]) begin
                    gap_log[g][falls[g] % 32] = hi_run[g];
                    cur_frame[g] = falls[g];
                    falls[g]++;
                    hi_run[g]  = 0;
                    bit_idx[g] = 0;
                end
                if (prev_sclk[g] && !sclk_v[g] && bit_idx[g] < 39) bit_idx[g]++;
                if (!prev_sclk[g] && sclk_v[g]) begin
                    rises[g]++;
                    mosi_cap[g] = {mosi_cap[g][38:0], mosi_v[g]};
                end
            end
            rv = resp_tab[g][cur_frame[g] % 32];
            if (cs_v[g] !== 1'b0 || bit_idx[g] < 8) miso_a[g] = 1'b0;
            else                                   miso_a[g] = rv[31 - (bit_idx[g] - 8)];
            prev_cs[g]   = (cs_v[g] !== 1'b0);
            prev_sclk[g] = (sclk_v[g] === 1'b1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int g);
        int k;
        k = 0;
        while (busy_v[g] !== 1'b0 && k < 200) begin
            @(posedge clk); #1; k++;
        end
        chk("busy_clears", {63'd0, busy_v[g]}, 64'd0);
        repeat (20) @(posedge clk);
        #1;
    endtask

    // One transaction: frame contents, latency, rdata, SCLK count, no extra frame
    task automatic run_frame(input int g, input logic rw, input logic [6:0] a,
                             input logic [31:0] wd, input logic [31:0] resp,
                             input int lat, input bit repulse);
        int r0, d0, t0, k;
        logic [39:0] exp_frame;
        exp_frame = {rw, a, (rw ? wd : 32'h0000_0000)};
        resp_tab[g][falls[g] % 32] = resp;
        r0 = rises[g];
        d0 = dones[g];
        @(posedge clk); #1;
        rw_v[g] = rw; addr_a[g] = a; wdata_a[g] = wd; start_v[g] = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start_v[g] = 1'b0; rw_v[g] = ~rw; addr_a[g] = ~a; wdata_a[g] = ~wd;
        k = 1;
        while (dones[g] == d0 && k < 5000) begin
            @(posedge clk); #1; k++;
            start_v[g] = repulse && (k == 10 || k == 100);
        end
        start_v[g] = 1'b0;
        wait_idle(g);
        chk("done_count", 64'(dones[g] - d0), 64'd1);
        chk("latency", 64'(done_cyc[g][d0 % 32] - t0), 64'(lat));
        chk("sclk_rises", 64'(rises[g] - r0), 64'd40);
        chk("mosi_frame", {24'd0, mosi_cap[g]}, {24'd0, exp_frame});
        chk("rdata_at_done", {32'd0, done_rd[g][d0 % 32]}, {32'd0, resp});
        chk("rdata_held", {32'd0, rdata_a[g]}, {32'd0, resp});
    endtask

    initial begin
        int r0, d0, f0, t0, k;
        logic [31:0] rsp [3];
        logic [6:0]  ra;
        logic [31:0] rw32;
        for (int g = 0; g < 2; g++) begin
            addr_a[g] = 7'd0; wdata_a[g] = 32'd0;
            for (int i = 0; i < 32; i++) resp_tab[g][i] = 32'd0;
        end

        // Reset state of both instances
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_cs",    {63'd0, cs_v[g]},   64'd1);
            chk("rst_sclk",  {63'd0, sclk_v[g]}, 64'd0);
            chk("rst_mosi",  {63'd0, mosi_v[g]}, 64'd0);
            chk("rst_busy",  {63'd0, busy_v[g]}, 64'd0);
            chk("rst_done",  {63'd0, done_v[g]}, 64'd0);
            chk("rst_rdata", {32'd0, rdata_a[g]}, 64'd0);
        end
        @(posedge clk); #1;
        reset_v = 2'b00;
        repeat (3) @(posedge clk);

        // Directed read and write
        run_frame(0, 1'b0, 7'h07, 32'hFFFF_FFFF, 32'hDEAD_BEEF, LAT0, 1'b0);
        run_frame(0, 1'b1, 7'h01, 32'h1234_5678, 32'hA5A5_0F0F, LAT0, 1'b0);
        chk("write_stream", {24'd0, mosi_cap[0]}, {24'd0, 40'h81_1234_5678});

        // Starts during an active frame are ignored
        run_frame(0, 1'b1, 7'h33, 32'h0BAD_F00D, 32'h1357_9BDF, LAT0, 1'b1);

        // start held high: three frames, 8 CS-high cycles apart
        f0 = falls[0]; r0 = rises[0]; d0 = dones[0];
        for (int i = 0; i < 3; i++) begin
            rsp[i] = $urandom;
            resp_tab[0][(f0 + i) % 32] = rsp[i];
        end
        @(posedge clk); #1;
        rw_v[0] = 1'b1; addr_a[0] = 7'h05; wdata_a[0] = 32'hCAFE_0123; start_v[0] = 1'b1;
        t0 = cyc; k = 0;
        while (dones[0] - d0 < 3 && k < 10000) begin
            @(posedge clk); #1; k++;
        end
        start_v[0] = 1'b0;
        wait_idle(0);
        chk("b2b_dones", 64'(dones[0] - d0), 64'd3);
        chk("b2b_latency", 64'(done_cyc[0][d0 % 32] - t0), 64'(LAT0));
        chk("b2b_rises", 64'(rises[0] - r0), 64'd120);
        chk("b2b_gap1", 64'(gap_log[0][(f0 + 1) % 32]), 64'd8);
        chk("b2b_gap2", 64'(gap_log[0][(f0 + 2) % 32]), 64'd8);
        for (int i = 0; i < 3; i++)
            chk("b2b_rdata", {32'd0, done_rd[0][(d0 + i) % 32]}, {32'd0, rsp[i]});
        chk("b2b_mosi", {24'd0, mosi_cap[0]}, {24'd0, 40'h85_CAFE_0123});

        // Reset in the middle of a frame
        resp_tab[0][falls[0] % 32] = 32'h7777_8888;
        r0 = rises[0];
        @(posedge clk); #1;
        rw_v[0] = 1'b1; addr_a[0] = 7'h02; wdata_a[0] = 32'h5555_AAAA; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        k = 0;
        while (rises[0] - r0 < 20 && k < 2000) begin
            @(negedge clk); k++;
        end
        d0 = dones[0];
        @(posedge clk); #1;
        reset_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_cs",    {63'd0, cs_v[0]},   64'd1);
        chk("mid_rst_sclk",  {63'd0, sclk_v[0]}, 64'd0);
        chk("mid_rst_busy",  {63'd0, busy_v[0]}, 64'd0);
        chk("mid_rst_done",  {63'd0, done_v[0]}, 64'd0);
        chk("mid_rst_rdata", {32'd0, rdata_a[0]}, 64'd0);
        @(posedge clk); #1;
        reset_v[0] = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("mid_rst_nodone", 64'(dones[0] - d0), 64'd0);
        chk("mid_rst_idle_cs", {63'd0, cs_v[0]}, 64'd1);
        run_frame(0, 1'b1, 7'h06, 32'h0F1E_2D3C, 32'h4B5A_6978, LAT0, 1'b0);

        // CLK_DIV=1 read
        run_frame(1, 1'b0, 7'h04, 32'h1111_2222, 32'h0000_0005, LAT1, 1'b0);

        // Randomized transactions on both instances
        for (int i = 0; i < 6; i++) begin
            ra   = 7'($urandom_range(0, 127));
            rw32 = $urandom;
            run_frame(i % 2, 1'($urandom_range(0, 1)), ra, rw32, $urandom,
                      (i % 2 == 0) ? LAT0 : LAT1, 1'b0);
        end

        for (int g = 0; g < 2; g++) begin
            chk("sclk_low_when_cs_high", 64'(sclk_bad[g]), 64'd0);
            chk("rdata_only_at_done", 64'(rdata_bad[g]), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
